accum_operand_fifo: RTL and testbench

Wishbone-slave operand buffer that sits directly upstream of the add/sub accumulator in the user project. The management SoC writes operand words and a per-operand opcode into a small FIFO. The block presents them to the accumulator as a valid/ready stream, captures returned results, and exposes FIFO status and the last result for readback. Firmware can queue several operations without polling the accumulator between them.

---
 rtl/accum_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/accum_operand_fifo.sv | 121 ++++++++++++
 tb/tb_accum_operand_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator operand buffer: register map,
// STATUS field positions and the queued entry layout.
package accum_pkg;

   localparam int DATA_W  = 32;
   localparam int ENTRY_W = DATA_W + 2;

   localparam logic [1:0] ADDR_OPERAND = 2'd0;
   localparam logic [1:0] ADDR_CTRL    = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_RESULT  = 2'd3;

   localparam int CTRL_NADD_SUB = 0;
   localparam int CTRL_USE_PREV = 1;
   localparam int CTRL_IRQ_EN   = 2;

   localparam int ST_COUNT_LSB = 0;
   localparam int ST_EMPTY     = 8;
   localparam int ST_FULL      = 9;
   localparam int ST_OVERFLOW  = 10;
   localparam int ST_RES_LSB   = 16;

   typedef struct packed {
      logic              nadd_sub;
      logic              use_prev;
      logic [DATA_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a head-visible output; a push into a full FIFO
// is accepted when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [4:0]       count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == 5'd0);
   assign full    = (count == 5'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/accum_operand_fifo.sv
// Wishbone-slave operand queue feeding the add/sub accumulator as a
// valid/ready stream, with CTRL/STATUS/RESULT registers for firmware.
module accum_operand_fifo
   import accum_pkg::*;
#(
   parameter int BITS  = 32,
   parameter int DEPTH = 4
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   output logic            op_valid,
   input  logic            op_ready,
   output logic [BITS-1:0] op_data,
   output logic            op_nadd_sub,
   output logic            op_use_prev,
   input  logic            res_valid,
   input  logic [BITS-1:0] res_data,
   output logic            fifo_irq
);

   logic            svc;
   logic            wr;
   logic [1:0]      reg_idx;
   logic [2:0]      ctrl;
   logic            overflow;
   logic [7:0]      res_count;
   logic [BITS-1:0] result;
   logic            push_req;
   logic            pop;
   logic            full;
   logic            empty;
   logic [4:0]      count;
   logic [31:0]     rdata;
   entry_t          push_ent;
   entry_t          head;
   logic            unused;

   assign unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

   // the !ack guard makes each request take exactly one service cycle
   assign svc      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign wr       = svc & wbs_we_i;
   assign reg_idx  = wbs_adr_i[3:2];
   assign push_req = wr & (reg_idx == ADDR_OPERAND) & (wbs_sel_i == 4'hF);
   assign pop      = op_valid & op_ready;

   // opcode is captured from CTRL at push time
   assign push_ent = '{nadd_sub: ctrl[CTRL_NADD_SUB],
                       use_prev: ctrl[CTRL_USE_PREV],
                       data:     wbs_dat_i};

   sync_fifo #(
      .WIDTH(ENTRY_W),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .push (push_req),
      .pop  (pop),
      .din  (push_ent),
      .dout (head),
      .full (full),
      .empty(empty),
      .count(count)
   );

   assign op_valid    = ~empty;
   assign op_data     = head.data;
   assign op_nadd_sub = head.nadd_sub;
   assign op_use_prev = head.use_prev;

   always_comb begin
      rdata = '0;
      case (reg_idx)
         ADDR_CTRL: rdata[2:0] = ctrl;
         ADDR_STATUS: begin
            rdata[ST_COUNT_LSB +: 5] = count;
            rdata[ST_EMPTY]          = empty;
            rdata[ST_FULL]           = full;
            rdata[ST_OVERFLOW]       = overflow;
            rdata[ST_RES_LSB +: 8]   = res_count;
         end
         ADDR_RESULT: rdata = result;
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         ctrl      <= '0;
         overflow  <= 1'b0;
         res_count <= '0;
         result    <= '0;
         fifo_irq  <= 1'b0;
      end else begin
         wbs_ack_o <= svc;
         if (svc) wbs_dat_o <= wbs_we_i ? 32'd0 : rdata;
         if (wr && reg_idx == ADDR_CTRL && wbs_sel_i[0]) ctrl <= wbs_dat_i[2:0];
         if (push_req && full && !pop)
            overflow <= 1'b1;
         else if (wr && reg_idx == ADDR_STATUS)
            overflow <= 1'b0;
         if (res_valid) begin
            result    <= res_data;
            res_count <= res_count + 8'd1;
         end
         fifo_irq <= empty & ctrl[CTRL_IRQ_EN];
      end
   end

endmodule

// File: tb/tb_accum_operand_fifo.sv
// Randomized bench for accum_operand_fifo against a queue-based model of
// the register map and operand stream.
module tb_accum_operand_fifo;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack;
   logic [31:0] rdat_o;
   logic        op_valid, op_ready;
   logic [31:0] op_data;
   logic        op_nadd_sub, op_use_prev;
   logic        res_valid;
   logic [31:0] res_data;
   logic        irq;

   always #5 clk = ~clk;

   accum_operand_fifo #(.BITS(32), .DEPTH(DEPTH)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wbs_stb_i  (stb),
      .wbs_cyc_i  (cyc),
      .wbs_we_i   (we),
      .wbs_sel_i  (sel),
      .wbs_adr_i  (adr),
      .wbs_dat_i  (wdat),
      .wbs_ack_o  (ack),
      .wbs_dat_o  (rdat_o),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_data    (op_data),
      .op_nadd_sub(op_nadd_sub),
      .op_use_prev(op_use_prev),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .fifo_irq   (irq)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          nadd;
      bit          use_p;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   bit   [2:0]  m_ctrl;
   bit          m_ovf;
   bit   [7:0]  m_rcnt;
   logic [31:0] m_res;
   bit          m_irq;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ctrl = 0; m_ovf = 0; m_rcnt = 0; m_res = 0; m_irq = 0;
   endtask

   function automatic logic [31:0] m_read(input int idx);
      case (idx)
         1: return {29'd0, m_ctrl};
         2: return {8'h0, m_rcnt, 5'h0, m_ovf, q.size() == DEPTH, q.size() == 0, 3'h0, 5'(q.size())};
         3: return m_res;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check_outs();
      chk("op_valid", 32'(op_valid), 32'(q.size() != 0));
      chk("op_data", op_data, q.size() != 0 ? q[0].d : 32'd0);
      chk("op_nadd_sub", 32'(op_nadd_sub), q.size() != 0 ? 32'(q[0].nadd) : 32'd0);
      chk("op_use_prev", 32'(op_use_prev), q.size() != 0 ? 32'(q[0].use_p) : 32'd0);
      chk("fifo_irq", 32'(irq), 32'(m_irq));
   endtask

   // one clock: drive inputs, check outputs, take the edge, update the model
   task automatic cycle(input bit req, input bit w, input int idx, input logic [31:0] d,
                        input logic [3:0] s, input bit rdy, input bit rv, input logic [31:0] rd);
      bit pop, full, irq_n;
      cyc = req; stb = req; we = w; adr = 32'(idx) << 2; wdat = d; sel = s;
      op_ready = rdy; res_valid = rv; res_data = rd;
      check_outs();
      pop   = rdy && q.size() > 0;
      full  = q.size() == DEPTH;
      irq_n = (q.size() == 0) && m_ctrl[2];
      @(posedge clk);
      #1;
      if (pop) void'(q.pop_front());
      if (req && w) begin
         case (idx)
            0: if (s == 4'hF) begin
                  if (!full || pop) q.push_back('{m_ctrl[0], m_ctrl[1], d});
                  else m_ovf = 1;
               end
            1: if (s[0]) m_ctrl = d[2:0];
            2: m_ovf = 0;
            default: ;
         endcase
      end
      if (rv) begin m_res = rd; m_rcnt++; end
      m_irq = irq_n;
      cyc = 0; stb = 0; we = 0; op_ready = 0; res_valid = 0;
   endtask

   task automatic wb_xfer(input bit w, input int idx, input logic [31:0] d, input logic [3:0] s,
                          input bit rdy, input bit rv, input logic [31:0] rd,
                          output logic [31:0] rdat);
      logic [31:0] exp;
      exp = m_read(idx);
      cycle(1, w, idx, d, s, rdy, rv, rd);
      chk("ack", 32'(ack), 32'd1);
      if (!w) chk($sformatf("read%0d", idx), rdat_o, exp);
      rdat = rdat_o;
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      chk("ack_drop", 32'(ack), 32'd0);
   endtask

   logic [31:0] r;
   logic [31:0] words[6];

   initial begin
      rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
      op_ready = 0; res_valid = 0; res_data = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 0;

      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_dat", rdat_o, 32'd0);
      check_outs();
      wb_xfer(0, 2, 0, 4'hF, 0, 0, 0, r);
      chk("rst_status", r, 32'h0000_0100);
      wb_xfer(0, 3, 0, 4'hF, 0, 0, 0, r);
      chk("rst_result", r, 32'd0);

      for (int i = 0; i < 256; i++) cycle(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      wb_xfer(0, 3, 0, 4'hF, 0, 0, 0, r);
      chk("result_beef", r, 32'hDEAD_BEEF);
      wb_xfer(0, 2, 0, 4'hF, 0, 0, 0, r);
      chk("res_count_wrap", (r >> 16) & 32'hFF, 32'd0);

      wb_xfer(1, 1, 32'h1, 4'h1, 0, 0, 0, r);
      wb_xfer(1, 0, 32'h0005_0003, 4'hF, 0, 0, 0, r);
      chk("first_data", op_data, 32'h0005_0003);
      chk("first_nadd", 32'(op_nadd_sub), 32'd1);
      chk("first_use", 32'(op_use_prev), 32'd0);
      wb_xfer(0, 2, 0, 4'hF, 0, 0, 0, r);
      chk("first_count", r & 32'h1F, 32'd1);
      cycle(0, 0, 0, 0, 0, 1, 0, 0);

      // overflow: five pushes into four slots
      for (int i = 0; i < 6; i++) words[i] = $urandom;
      for (int i = 0; i < 5; i++) wb_xfer(1, 0, words[i], 4'hF, 0, 0, 0, r);
      wb_xfer(0, 2, 0, 4'hF, 0, 0, 0, r);
      chk("ovf_bits", r & 32'h71F, 32'h604);
      wb_xfer(1, 2, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
      wb_xfer(0, 2, 0, 4'hF, 0, 0, 0, r);
      chk("ovf_clear", r & 32'h71F, 32'h204);
      // push while full with a concurrent pop
      wb_xfer(1, 0, words[5], 4'hF, 1, 0, 0, r);
      wb_xfer(0, 2, 0, 4'hF, 0, 0, 0, r);
      chk("full_pushpop", r & 32'h71F, 32'h204);
      chk("head_w2", op_data, words[1]);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0);
      chk("last_w6", op_data, words[5]);
      cycle(0, 0, 0, 0, 0, 1, 0, 0);

      // RESULT read coinciding with a capture returns the old value
      wb_xfer(0, 3, 0, 4'hF, 0, 1, 32'h1234_5678, r);
      chk("result_old", r, 32'hDEAD_BEEF);

      for (int n = 0; n < 400; n++) begin
         int act;
         bit rdy, rv;
         logic [31:0] d;
         act = $urandom_range(0, 6);
         rdy = ($urandom_range(0, 2) == 0);
         rv  = ($urandom_range(0, 3) == 0);
         d   = $urandom;
         case (act)
            0, 1: wb_xfer(1, 0, d, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF, rdy, rv, $urandom, r);
            2: wb_xfer(0, $urandom_range(0, 3), 0, 4'hF, rdy, rv, $urandom, r);
            3: wb_xfer(1, 1, d, 4'($urandom), rdy, rv, $urandom, r);
            4: wb_xfer(1, $urandom_range(2, 3), d, 4'hF, rdy, rv, $urandom, r);
            default: cycle(0, 0, 0, 0, 0, rdy, rv, $urandom);
         endcase
      end

      // reset with an entry queued and a request in flight
      wb_xfer(1, 0, 32'hA5A5_0001, 4'hF, 0, 0, 0, r);
      cyc = 1; stb = 1; we = 0; adr = 32'h8; res_valid = 1; res_data = 32'h5555_AAAA;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0; cyc = 0; stb = 0; res_valid = 0;
      model_reset();
      chk("rst_mid_ack", 32'(ack), 32'd0);
      chk("rst_mid_valid", 32'(op_valid), 32'd0);
      wb_xfer(0, 2, 0, 4'hF, 0, 0, 0, r);
      chk("rst_mid_status", r, 32'h0000_0100);
      wb_xfer(0, 3, 0, 4'hF, 0, 0, 0, r);
      chk("rst_mid_result", r, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
